pipe_stage_chain: RTL

PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

---
 rtl/pipe_stage_chain.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: a chain of DEPTH pipeline register slots with per-slot
// stall/bubble/hold control, a flush that empties every slot, a registered
// delay-slot hint fed back upstream, and two saturating activity counters.
//
// Ports:
//   clk         - single clock, all state on the rising edge
//   rst         - synchronous active-high reset
//   stall       - stall vector; slot k looks at bits BASE+k and BASE+k+1
//   flush       - turn every slot into a bubble
//   in_data     - upstream payload
//   in_valid    - upstream payload is a real instruction
//   in_ds       - upstream instruction sits in a delay slot
//   next_ds_i   - the next instruction will be in a delay slot
//   out_data    - payload of the last slot
//   out_valid   - last slot holds a real instruction
//   out_ds      - delay-slot flag of the last slot
//   ds_hold_o   - next_ds_i captured whenever slot 0 advances
//   bubble_cnt  - saturating count of edges seen with out_valid low
//   hold_cnt    - saturating count of edges where the last slot held
module pipe_stage_chain #(
  parameter int unsigned   DW      = 32,
  parameter int unsigned   DEPTH   = 1,
  parameter int unsigned   BASE    = 2,
  parameter int unsigned   STALL_W = 6,
  parameter logic [DW-1:0] NOP_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [DW-1:0]      in_data,
  input  logic               in_valid,
  input  logic               in_ds,
  input  logic               next_ds_i,
  output logic [DW-1:0]      out_data,
  output logic               out_valid,
  output logic               out_ds,
  output logic               ds_hold_o,
  output logic [15:0]        bubble_cnt,
  output logic [15:0]        hold_cnt
);

  // Registered contents of every slot, gathered so slot k can read slot k-1.
  logic [DW-1:0] slot_data  [DEPTH];
  logic          slot_valid [DEPTH];
  logic          slot_ds    [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    logic          s;
    logic          n;
    logic [DW-1:0] src_data;
    logic          src_valid;
    logic          src_ds;
    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          ds_q, ds_d;

    // s stops this slot; n says the downstream slot is also stopped.
    assign s = stall[BASE+k];
    assign n = stall[BASE+k+1];

    if (k == 0) begin : g_src_in
      assign src_data  = in_data;
      assign src_valid = in_valid;
      assign src_ds    = in_ds;
    end else begin : g_src_prev
      assign src_data  = slot_data[k-1];
      assign src_valid = slot_valid[k-1];
      assign src_ds    = slot_ds[k-1];
    end

    // Default is hold (s=1, n=1). A stopped slot whose consumer keeps moving
    // must emit a bubble, otherwise its item would be duplicated downstream.
    always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ds_d    = ds_q;
      if (flush || (s && !n)) begin
        data_d  = NOP_VAL;
        valid_d = 1'b0;
        ds_d    = 1'b0;
      end else if (!s) begin
        data_d  = src_valid ? src_data : NOP_VAL;
        valid_d = src_valid;
        ds_d    = src_ds;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        data_q  <= NOP_VAL;
        valid_q <= 1'b0;
        ds_q    <= 1'b0;
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
        ds_q    <= ds_d;
      end
    end

    assign slot_data[k]  = data_q;
    assign slot_valid[k] = valid_q;
    assign slot_ds[k]    = ds_q;
  end

  // Outputs come straight from the last slot's registers.
  assign out_data  = slot_data[DEPTH-1];
  assign out_valid = slot_valid[DEPTH-1];
  assign out_ds    = slot_ds[DEPTH-1];

  // Delay-slot hint: only refreshed when slot 0 actually takes a new item,
  // so it stays aligned with what upstream presented.
  logic ds_hold_q, ds_hold_d;

  always_comb begin
    ds_hold_d = ds_hold_q;
    if (flush) begin
      ds_hold_d = 1'b0;
    end else if (!stall[BASE]) begin
      ds_hold_d = next_ds_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ds_hold_q <= 1'b0;
    end else begin
      ds_hold_q <= ds_hold_d;
    end
  end

  assign ds_hold_o = ds_hold_q;

  // Activity counters. Flush wins over hold, so a flushing edge never counts
  // as a hold; flush itself leaves both counters alone.
  logic        last_hold;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;

  assign last_hold = stall[BASE+DEPTH-1] & stall[BASE+DEPTH] & ~flush;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    if (!out_valid && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
    if (last_hold && (hold_cnt_q != 16'hFFFF)) begin
      hold_cnt_d = hold_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= 16'd0;
      hold_cnt_q   <= 16'd0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign hold_cnt   = hold_cnt_q;

  // Stall bits outside BASE..BASE+DEPTH are deliberately ignored.
  logic unused_stall;
  assign unused_stall = ^stall;

endmodule
